// File: rtl/mem_io_arbiter.sv
// Two-master (CPU / UART loader) arbiter onto one memory port and a LED/switch IO pair.
// Round-robin on ties; each granted access runs IDLE -> ACCESS -> [WAIT] -> DONE.
module mem_io_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] LED_ADDR    = 32'hFFFFFC60,
    parameter logic [31:0] SW_ADDR     = 32'hFFFFFC70
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_ack,
    input  logic        u_req,
    input  logic        u_we,
    input  logic [31:0] u_addr,
    input  logic [31:0] u_wdata,
    output logic        u_ack,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        led_cs,
    output logic        sw_cs,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] LAST = 3'(MEM_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic        prio_u;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  cnt;
    logic        gnt_c;
    logic        gnt_u;
    logic        is_io;
    logic        is_last;
    logic        in_access;

    // prio_u set means the loader wins the next tie
    assign gnt_c     = (state == IDLE) && c_req && (!u_req || !prio_u);
    assign gnt_u     = (state == IDLE) && u_req && (!c_req || prio_u);
    assign is_io     = (lat_addr[31:10] == 22'h3FFFFF);
    assign is_last   = (cnt == LAST);
    assign in_access = (state == ACCESS);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_c || gnt_u) state_nxt = ACCESS;
            ACCESS:  state_nxt = (!lat_we && !is_io) ? WAIT : DONE;
            WAIT:    if (is_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner     <= 1'b0;
            prio_u    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rdata     <= '0;
        end else begin
            if (gnt_c || gnt_u) begin
                owner     <= gnt_u;
                prio_u    <= gnt_c;
                lat_we    <= gnt_u ? u_we    : c_we;
                lat_addr  <= gnt_u ? u_addr  : c_addr;
                lat_wdata <= gnt_u ? u_wdata : c_wdata;
            end
            if (in_access) begin
                cnt <= '0;
                if (!lat_we && is_io)
                    rdata <= (lat_addr == SW_ADDR) ? {16'h0, io_rdata} : 32'h0;
            end
            if (state == WAIT) begin
                cnt <= cnt + 3'd1;
                if (is_last) rdata <= mem_rdata;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign mem_en    = in_access && !is_io;
    assign mem_we    = in_access && !is_io && lat_we;
    assign led_cs    = in_access && is_io && lat_we && (lat_addr == LED_ADDR);
    assign sw_cs     = in_access && is_io && !lat_we && (lat_addr == SW_ADDR);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign io_wdata  = lat_wdata[15:0];
    assign c_ack     = (state == DONE) && !owner;
    assign u_ack     = (state == DONE) && owner;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Randomized self-checking bench for mem_io_arbiter against a transaction-level model.
module tb_mem_io_arbiter;

    localparam int          LAT = 1;
    localparam logic [31:0] LED = 32'hFFFFFC60;
    localparam logic [31:0] SW  = 32'hFFFFFC70;

    logic        clock = 1'b0;
    logic        reset;
    logic        c_req, c_we, u_req, u_we;
    logic [31:0] c_addr, c_wdata, u_addr, u_wdata;
    logic        c_ack, u_ack;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        led_cs, sw_cs;
    logic [15:0] io_wdata, io_rdata;
    logic        busy, owner;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_rdata = 32'h0;

    typedef struct {
        int          ack_cyc;
        int          acks;
        int          wrong;
        int          men;
        int          mwe;
        int          led;
        int          sw;
        logic [31:0] addr_s;
        logic [31:0] wd_s;
        logic [15:0] iow_s;
        logic [31:0] rd;
        logic        own;
    } obs_t;

    always #5 clock = ~clock;

    mem_io_arbiter #(
        .MEM_LATENCY(LAT),
        .LED_ADDR   (LED),
        .SW_ADDR    (SW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_ack    (c_ack),
        .u_req    (u_req),
        .u_we     (u_we),
        .u_addr   (u_addr),
        .u_wdata  (u_wdata),
        .u_ack    (u_ack),
        .rdata    (rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .led_cs   (led_cs),
        .sw_cs    (sw_cs),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    function automatic bit is_io(input logic [31:0] a);
        return a[31:10] == 22'h3FFFFF;
    endfunction

    // Cycles from the sampling edge to ack
    function automatic int exp_lat(input bit we, input logic [31:0] a);
        return (!we && !is_io(a)) ? 2 + LAT : 2;
    endfunction

    task automatic model_update(input bit we, input logic [31:0] a,
                                input logic [31:0] mrd, input logic [15:0] iord);
        if (!we) begin
            if (!is_io(a))   model_rdata = mrd;
            else if (a == SW) model_rdata = {16'h0, iord};
            else             model_rdata = 32'h0;
        end
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        u_req = 0; u_we = 0; u_addr = 0; u_wdata = 0;
        mem_rdata = 0; io_rdata = 0;
    endtask

    // One isolated access; request dropped and bus scrambled right after the grant edge
    task automatic run_txn(input bit who, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] mrd,
                           input logic [15:0] iord, output obs_t o);
        o.ack_cyc = -1; o.acks = 0; o.wrong = 0; o.men = 0; o.mwe = 0;
        o.led = 0; o.sw = 0; o.addr_s = 0; o.wd_s = 0; o.iow_s = 0;
        o.rd = 0; o.own = 0;
        @(negedge clock);
        mem_rdata = mrd;
        io_rdata  = iord;
        if (who) begin u_req = 1; u_we = we; u_addr = addr; u_wdata = wd; end
        else     begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wd; end
        @(posedge clock);
        #1;
        c_req = 0; u_req = 0;
        c_addr = $urandom; u_addr = $urandom;
        c_wdata = $urandom; u_wdata = $urandom;
        c_we = 1'($urandom_range(0, 1)); u_we = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (mem_en) begin o.men++; o.addr_s = mem_addr; o.wd_s = mem_wdata; end
            if (mem_we) o.mwe++;
            if (led_cs) begin o.led++; o.iow_s = io_wdata; end
            if (sw_cs)  o.sw++;
            if (who ? u_ack : c_ack) begin
                o.acks++;
                if (o.ack_cyc < 0) o.ack_cyc = k;
                o.rd  = rdata;
                o.own = owner;
            end
            if (who ? c_ack : u_ack) o.wrong++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        c_req = 1; u_req = 1; c_addr = 32'h44; u_addr = 32'h88;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({busy, c_ack, u_ack, owner, mem_en, mem_we, led_cs, sw_cs} !== 8'h0) begin
            n_err++;
            $display("FAIL reset_ctl got %b exp 00000000",
                     {busy, c_ack, u_ack, owner, mem_en, mem_we, led_cs, sw_cs});
        end
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_rdata got %h exp 0", rdata);
        end
        n_cmp++;
        if (mem_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_latch got %h exp 0", mem_addr);
        end
        idle_inputs();
        reset = 1;
        model_rdata = 32'h0;
    endtask

    task automatic test_cpu_write();
        obs_t o;
        run_txn(0, 1, 32'h10, 32'h12345678, 32'h0, 16'h0, o);
        model_update(1, 32'h10, 32'h0, 16'h0);
        n_cmp++;
        if (o.ack_cyc !== 2) begin n_err++; $display("FAIL wr_ack_cyc got %0d exp 2", o.ack_cyc); end
        n_cmp++;
        if (o.acks !== 1 || o.wrong !== 0) begin
            n_err++; $display("FAIL wr_ack_cnt got %0d/%0d exp 1/0", o.acks, o.wrong);
        end
        n_cmp++;
        if (o.men !== 1 || o.mwe !== 1) begin
            n_err++; $display("FAIL wr_strobe got en%0d we%0d exp 1 1", o.men, o.mwe);
        end
        n_cmp++;
        if (o.addr_s !== 32'h10 || o.wd_s !== 32'h12345678) begin
            n_err++; $display("FAIL wr_bus got %h/%h exp 10/12345678", o.addr_s, o.wd_s);
        end
        n_cmp++;
        if (o.rd !== model_rdata) begin
            n_err++; $display("FAIL wr_rdata got %h exp %h", o.rd, model_rdata);
        end
    endtask

    task automatic test_cpu_read();
        obs_t o;
        run_txn(0, 0, 32'h10, 32'h0, 32'hCAFEF00D, 16'h0, o);
        model_update(0, 32'h10, 32'hCAFEF00D, 16'h0);
        n_cmp++;
        if (o.ack_cyc !== 2 + LAT) begin
            n_err++; $display("FAIL rd_ack_cyc got %0d exp %0d", o.ack_cyc, 2 + LAT);
        end
        n_cmp++;
        if (o.men !== 1 || o.mwe !== 0 || o.acks !== 1) begin
            n_err++; $display("FAIL rd_strobe got en%0d we%0d ack%0d exp 1 0 1", o.men, o.mwe, o.acks);
        end
        n_cmp++;
        if (o.rd !== model_rdata) begin
            n_err++; $display("FAIL rd_rdata got %h exp %h", o.rd, model_rdata);
        end
    endtask

    task automatic test_io_loader();
        obs_t o;
        run_txn(1, 0, SW, 32'h0, 32'h0, 16'hA5A5, o);
        model_update(0, SW, 32'h0, 16'hA5A5);
        n_cmp++;
        if (o.sw !== 1 || o.men !== 0 || o.led !== 0) begin
            n_err++; $display("FAIL sw_strobe got sw%0d en%0d led%0d exp 1 0 0", o.sw, o.men, o.led);
        end
        n_cmp++;
        if (o.ack_cyc !== 2 || o.acks !== 1 || o.wrong !== 0) begin
            n_err++; $display("FAIL sw_ack got cyc%0d n%0d w%0d exp 2 1 0", o.ack_cyc, o.acks, o.wrong);
        end
        n_cmp++;
        if (o.rd !== 32'h0000A5A5 || o.own !== 1'b1) begin
            n_err++; $display("FAIL sw_rdata got %h own%b exp 0000a5a5 own1", o.rd, o.own);
        end
        run_txn(1, 0, 32'hFFFFFC00, 32'h0, 32'h11111111, 16'h7777, o);
        model_update(0, 32'hFFFFFC00, 32'h11111111, 16'h7777);
        n_cmp++;
        if (o.sw + o.led + o.men !== 0) begin
            n_err++; $display("FAIL unmapped_strobe got %0d exp 0", o.sw + o.led + o.men);
        end
        n_cmp++;
        if (o.ack_cyc !== 2 || o.rd !== 32'h0) begin
            n_err++; $display("FAIL unmapped_rd got cyc%0d %h exp 2 0", o.ack_cyc, o.rd);
        end
        run_txn(1, 1, LED, 32'hDEADBEEF, 32'h0, 16'h0, o);
        model_update(1, LED, 32'h0, 16'h0);
        n_cmp++;
        if (o.led !== 1 || o.iow_s !== 16'hBEEF || o.men !== 0) begin
            n_err++; $display("FAIL led_wr got led%0d %h en%0d exp 1 beef 0", o.led, o.iow_s, o.men);
        end
        n_cmp++;
        if (o.ack_cyc !== 2 || o.rd !== model_rdata) begin
            n_err++; $display("FAIL led_ack got cyc%0d %h exp 2 %h", o.ack_cyc, o.rd, model_rdata);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        bit          who, we, io;
        logic [31:0] a, wd, mrd;
        logic [15:0] iord;
        for (int i = 0; i < 24; i++) begin
            who  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            mrd  = $urandom;
            iord = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       a = $urandom & 32'h7FFFFFFC;
                1:       a = LED;
                2:       a = SW;
                default: a = {22'h3FFFFF, 10'($urandom)};
            endcase
            io = is_io(a);
            run_txn(who, we, a, wd, mrd, iord, o);
            model_update(we, a, mrd, iord);
            n_cmp++;
            if (o.ack_cyc !== exp_lat(we, a) || o.acks !== 1 || o.wrong !== 0) begin
                n_err++;
                $display("FAIL rnd%0d ack got cyc%0d n%0d w%0d exp %0d 1 0",
                         i, o.ack_cyc, o.acks, o.wrong, exp_lat(we, a));
            end
            n_cmp++;
            if (o.men !== int'(!io) || o.mwe !== int'(!io && we)) begin
                n_err++;
                $display("FAIL rnd%0d mem got en%0d we%0d exp %0d %0d",
                         i, o.men, o.mwe, int'(!io), int'(!io && we));
            end
            n_cmp++;
            if (o.led !== int'(io && we && a == LED) || o.sw !== int'(io && !we && a == SW)) begin
                n_err++;
                $display("FAIL rnd%0d io got led%0d sw%0d exp %0d %0d", i, o.led, o.sw,
                         int'(io && we && a == LED), int'(io && !we && a == SW));
            end
            if (!io) begin
                n_cmp++;
                if (o.addr_s !== a || (we && o.wd_s !== wd)) begin
                    n_err++;
                    $display("FAIL rnd%0d bus got %h/%h exp %h/%h", i, o.addr_s, o.wd_s, a, wd);
                end
            end
            n_cmp++;
            if (o.rd !== model_rdata || o.own !== who) begin
                n_err++;
                $display("FAIL rnd%0d rdata got %h own%b exp %h own%b",
                         i, o.rd, o.own, model_rdata, who);
            end
        end
    endtask

    task automatic test_reset_wait();
        obs_t o;
        int   stray;
        stray = 0;
        @(negedge clock);
        mem_rdata = 32'h5A5A1234;
        c_req = 1; c_we = 0; c_addr = 32'h40;
        @(posedge clock);
        @(posedge clock);
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rw_pre_busy got %b exp 1", busy); end
        reset = 0;
        #1;
        n_cmp++;
        if ({busy, c_ack, u_ack, mem_en, mem_we, led_cs, sw_cs} !== 7'h0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rw_abort got %b %h exp 0000000 0",
                     {busy, c_ack, u_ack, mem_en, mem_we, led_cs, sw_cs}, rdata);
        end
        model_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (c_ack || u_ack || busy) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_err++; $display("FAIL rw_hold got %0d exp 0", stray); end
        reset = 1;
        @(posedge clock);
        #1;
        c_req = 0;
        o.ack_cyc = -1; o.acks = 0; o.rd = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (c_ack) begin
                o.acks++;
                if (o.ack_cyc < 0) o.ack_cyc = k;
                o.rd = rdata;
            end
        end
        model_update(0, 32'h40, 32'h5A5A1234, 16'h0);
        n_cmp++;
        if (o.ack_cyc !== 2 + LAT || o.acks !== 1) begin
            n_err++; $display("FAIL rw_resume got cyc%0d n%0d exp %0d 1", o.ack_cyc, o.acks, 2 + LAT);
        end
        n_cmp++;
        if (o.rd !== model_rdata) begin
            n_err++; $display("FAIL rw_rdata got %h exp %h", o.rd, model_rdata);
        end
    endtask

    task automatic test_rr();
        int          seq[$];
        logic [31:0] saddr[$];
        int          both;
        both = 0;
        @(negedge clock);
        reset = 0;
        idle_inputs();
        c_req = 1; c_we = 1; c_addr = 32'h100; c_wdata = 32'hC0;
        u_req = 1; u_we = 1; u_addr = 32'h200; u_wdata = 32'hD0;
        @(negedge clock);
        reset = 1;
        model_rdata = 32'h0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clock);
            if (k == 30) begin c_req = 0; u_req = 0; end
            if (c_ack && u_ack) both++;
            else if (c_ack)     seq.push_back(0);
            else if (u_ack)     seq.push_back(1);
            if (mem_en) saddr.push_back(mem_addr);
        end
        n_cmp++;
        if (seq.size() < 8 || both !== 0) begin
            n_err++; $display("FAIL rr_count got %0d both%0d exp >=8 0", seq.size(), both);
        end
        n_cmp++;
        if (saddr.size() !== seq.size()) begin
            n_err++; $display("FAIL rr_one_ack got %0d acks exp %0d", seq.size(), saddr.size());
        end
        for (int i = 0; i < seq.size(); i++) begin
            n_cmp++;
            if (seq[i] !== i % 2) begin
                n_err++; $display("FAIL rr_order%0d got %0d exp %0d", i, seq[i], i % 2);
            end
        end
        for (int i = 0; i < saddr.size(); i++) begin
            n_cmp++;
            if (saddr[i] !== ((i % 2) ? 32'h200 : 32'h100)) begin
                n_err++;
                $display("FAIL rr_addr%0d got %h exp %h", i, saddr[i], (i % 2) ? 32'h200 : 32'h100);
            end
        end
        n_cmp++;
        if (rdata !== model_rdata) begin
            n_err++; $display("FAIL rr_rdata got %h exp %h", rdata, model_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_io_loader();
        test_random();
        test_reset_wait();
        test_rr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_io_arbiter.md
MEM_IO_ARBITER -- requirements
Module: mem_io_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, memory read latency in cycles, legal range 1..7.
REQ-002 SHALL have parameter LED_ADDR, default 32'hFFFFFC60, LED register address.
REQ-003 SHALL have parameter SW_ADDR, default 32'hFFFFFC70, switch register address.
REQ-004 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset (0 = reset)
  c_req / c_we  in  1/1  CPU request, CPU write enable
  c_addr / c_wdata  in  32/32  CPU address, CPU write data
  c_ack  out  1  CPU completion pulse
  u_req / u_we  in  1/1  UART-loader request, write enable
  u_addr / u_wdata  in  32/32  loader address, write data
  u_ack  out  1  loader completion pulse
  rdata  out  32  read data, valid in ack cycle
  mem_en / mem_we  out  1/1  memory strobe, memory write
  mem_addr / mem_wdata  out  32/32  memory address, write data
  mem_rdata  in  32  memory read data
  led_cs / sw_cs  out  1/1  LED write select, switch read select
  io_wdata  out  16  LED data (wdata[15:0])
  io_rdata  in  16  switch data
  busy  out  1  high in any state other than IDLE
  owner  out  1  current/last grantee, 0 = CPU, 1 = loader

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE.
REQ-006 SHALL, in IDLE, grant the single requester when exactly one of c_req/u_req is high.
REQ-007 SHALL, when both request in IDLE, grant the requester that was not granted last (round-robin).
REQ-008 SHALL, on grant, latch we/addr/wdata of the grantee, set owner, and move to ACCESS next cycle.
REQ-009 SHALL decode addr[31:10] == 22'h3FFFFF as IO region, all other addresses as memory.
REQ-010 SHALL, in ACCESS, assert for exactly one cycle: mem_en (and mem_we for writes) for memory, led_cs for IO write to LED_ADDR, sw_cs for IO read from SW_ADDR.
REQ-011 SHALL assert no strobe for IO addresses other than LED_ADDR/SW_ADDR; reads there return 32'h0; ack still issued.
REQ-012 SHALL drive mem_addr/mem_wdata/io_wdata from latched values only; strobes are 0 outside ACCESS.
REQ-013 SHALL go ACCESS->DONE for writes and IO reads; IO read captures {16'h0, io_rdata} into rdata in ACCESS.
REQ-014 SHALL go ACCESS->WAIT for memory reads, count MEM_LATENCY cycles, capture mem_rdata into rdata on the last WAIT cycle, then go DONE.
REQ-015 SHALL pulse the grantee's ack for exactly one cycle in DONE, then return to IDLE.
REQ-016 SHALL hold rdata until the next read completes; writes leave rdata unchanged.
REQ-017 Latency from req sampled in IDLE (cycle T): write/IO read ack at T+2; memory read ack at T+2+MEM_LATENCY.
REQ-018 SHALL complete a latched access even if the requester drops req before ack.
REQ-019 SHALL treat req still high in the cycle after DONE as a new request; one ack per granted access.
REQ-020 SHALL ignore requests arriving while busy until IDLE; the non-granted requester is never dropped.

Reset
REQ-021 SHALL, while reset = 0, force state IDLE, all strobes 0, c_ack = u_ack = 0, rdata = 0, busy = 0, owner = 0, WAIT counter = 0, latched request = 0.
REQ-022 SHALL initialise the round-robin pointer so the CPU wins the first tie.
REQ-023 SHALL abort any access in progress on reset, with no ack issued.

Verification
REQ-024 CPU write 0x1234_5678 to 0x0000_0010 -> one-cycle mem_en=mem_we=1, mem_addr=0x10, c_ack at T+2.
REQ-025 CPU read 0x10, mem_rdata=0xCAFE_F00D, MEM_LATENCY=1 -> c_ack at T+3, rdata=0xCAFEF00D.
REQ-026 Both request continuously from reset -> grants C,U,C,U alternating; each ack exactly once per access.
REQ-027 Loader read SW_ADDR with io_rdata=0xA5A5 -> sw_cs one cycle, u_ack at T+2, rdata=0x0000A5A5; read of 0xFFFFFC00 -> no strobe, rdata=0.
REQ-028 Assert reset during WAIT -> strobes/ack/busy low immediately; after release, pending c_req served from IDLE.
